thread_issue_scheduler: RTL and testbench
=========================================

# thread_issue_scheduler

Barrel-thread issue scheduler for the Datapath. Each cycle it selects the next thread in round-robin order and drives that thread's registered memory-offset set into the Datapath (`read_addr_A_offset`, `read_addr_B_offset`, `write_addr_A_offset`, `write_addr_B_offset`). It tracks each issued slot down the pipeline and uses the returning `IO_ready` to decide advance versus replay. It also keeps per-thread consecutive-replay counters that raise a stall alarm.

## Interface
- `THREAD_COUNT`, 8, number of barrel threads (power of 2)
- `THREAD_ADDR_WIDTH`, 3, log2(THREAD_COUNT)
- `READ_ADDR_WIDTH`, 10, read offset width
- `WRITE_ADDR_WIDTH`, 12, write offset width
- `ISSUE_PIPE_DEPTH`, 8, cycles from issue to the matching `IO_ready` (≥2)
- `STALL_LIMIT`, 255, consecutive replays that raise the alarm (≤255)
---
- `clock` in 1: single clock, all logic on posedge
- `reset_n` in 1: asynchronous, active-low reset
- `thread_enable` in THREAD_COUNT: per-thread enable; a disabled thread's slot issues a bubble
- `cfg_wren` in 1: write one offset table entry
- `cfg_thread` in THREAD_ADDR_WIDTH: target thread
- `cfg_sel` in 2: 0 = read A, 1 = read B, 2 = write A, 3 = write B
- `cfg_data` in WRITE_ADDR_WIDTH: offset value; read offsets take the low READ_ADDR_WIDTH bits
- `IO_ready` in 1: from Datapath, belongs to the slot issued ISSUE_PIPE_DEPTH cycles earlier
- `issue_thread` out THREAD_ADDR_WIDTH: thread owning the current slot
- `issue_valid` out 1: slot carries a real instruction
- `read_addr_A_offset`, `read_addr_B_offset` out READ_ADDR_WIDTH each: offsets for `issue_thread`
- `write_addr_A_offset`, `write_addr_B_offset` out WRITE_ADDR_WIDTH each: offsets for `issue_thread`
- `retire_thread` out THREAD_ADDR_WIDTH: thread of the returning slot
- `retire_advance` out 1: retire valid and `IO_ready`=1; PC advances
- `retire_replay` out 1: retire valid and `IO_ready`=0; instruction re-issues
- `stall_alarm` out THREAD_COUNT: sticky per-thread flag, cleared only by reset

## Operation
- Thread counter: increments by 1 modulo THREAD_COUNT every cycle. It never skips, so slot timing stays fixed.
- `issue_valid` = `thread_enable[issue_thread]`, sampled in the cycle the slot is formed.
- Offset table: 4×THREAD_COUNT registers. Offset outputs are registered and aligned with `issue_thread`/`issue_valid`.
- Table write/read same cycle, same entry: the lookup returns the old value; the new value is visible from the next lookup.
- Delay line: ISSUE_PIPE_DEPTH stages of {thread, valid} produce `retire_thread`, with retire_valid internal.
- A bubble retire (valid=0) asserts neither advance nor replay, and `IO_ready` is ignored.
- Replay counters: one 8-bit counter per thread. Each `retire_replay` increments the counter, saturating at 255. Each `retire_advance` clears it. When the counter reaches STALL_LIMIT, the thread's `stall_alarm` bit sets.
- Disabling a thread does not clear its counter or alarm.

## Timing
- Reset values:
  - thread counter 0, `issue_thread`=0, `issue_valid`=0
  - all offsets 0, offset table 0
  - delay line all invalid
  - `retire_thread`=0, `retire_advance`=0, `retire_replay`=0
  - counters 0, `stall_alarm`=0
- First cycle after `reset_n` rises: `issue_thread`=0, `issue_valid`=`thread_enable[0]`.
- Table write to visible offset: the offset appears at the next slot of that thread. Worst case THREAD_COUNT cycles; at least 1.
- Issue to retire: exactly ISSUE_PIPE_DEPTH cycles. `retire_*` are combinational from the delay-line tail and `IO_ready`.
- Reset asserted mid-operation: all state clears immediately. In-flight slots are dropped and produce no retire pulse.

## Structure
- Shared package holds:
  - the `cfg_sel` encodings (OFS_RD_A, OFS_RD_B, OFS_WR_A, OFS_WR_B)
  - the replay-counter width of 8
- Sub-module `thread_slot_delay`: parameterised shift register of {thread, valid} with asynchronous clear. It is reusable by later pipeline trackers.

## Test plan
- Reset release with all threads enabled → `issue_thread` sequence is 0,1,…,7,0. `issue_valid`=1 throughout. All offsets 0.
- Write thread 3 with `cfg_sel`=1, `cfg_data`=0x2A, in the cycle before thread 3 issues → at the next thread-3 slot `read_addr_B_offset`=0x2A. Other threads still read 0.
- `thread_enable`=0xFD (thread 1 disabled) → every thread-1 slot has `issue_valid`=0. Eight cycles later (ISSUE_PIPE_DEPTH=8) neither `retire_advance` nor `retire_replay` is asserted, even with `IO_ready`=0.
- Hold `IO_ready`=0 for every slot → `retire_replay` every cycle. With STALL_LIMIT=4, `stall_alarm` bits set after the 4th retire of each thread. Then `IO_ready`=1 gives `retire_advance`, the alarm stays set, and the counter returns to 0.
- Assert `reset_n`=0 with slots in flight → the next cycle shows no retire pulses. After release, the first retire appears exactly ISSUE_PIPE_DEPTH cycles after the first issue.

Source files
------------

// File: rtl/thread_issue_scheduler_pkg.sv
// Shared types for the barrel-thread issue scheduler: offset-table select
// encodings and the per-thread replay-counter type.
package thread_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    OFS_RD_A = 2'd0,
    OFS_RD_B = 2'd1,
    OFS_WR_A = 2'd2,
    OFS_WR_B = 2'd3
  } ofs_sel_e;

  localparam int REPLAY_CNT_W = 8;

  typedef logic [REPLAY_CNT_W-1:0] replay_cnt_t;

  localparam replay_cnt_t REPLAY_CNT_MAX = '1;

  function automatic replay_cnt_t sat_inc(input replay_cnt_t value);
    return (value == REPLAY_CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/thread_slot_delay.sv
// Fixed-depth shift register of {thread, valid} tags with asynchronous clear,
// used to line an issued slot up with its returning pipeline status.
module thread_slot_delay #(
  parameter int DEPTH    = 8,
  parameter int THREAD_W = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [THREAD_W-1:0] in_thread,
  input  logic                in_valid,
  output logic [THREAD_W-1:0] out_thread,
  output logic                out_valid
);

  logic [THREAD_W-1:0] thread_q [DEPTH];
  logic [THREAD_W-1:0] thread_d [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    valid_d;

  // NOTE: every variable in an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    thread_d[0] = in_thread;
    for (int i = 1; i < DEPTH; i++) begin
      thread_d[i] = thread_q[i-1];
    end
    valid_d = {valid_q[DEPTH-2:0], in_valid};
  end

  // NOTE: the thread tags are cleared along with the valid bits so the tail reads thread 0 out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        thread_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      thread_q <= thread_d;
      valid_q  <= valid_d;
    end
  end

  assign out_thread = thread_q[DEPTH-1];
  assign out_valid  = valid_q[DEPTH-1];

endmodule

// File: rtl/thread_issue_scheduler.sv
// Round-robin barrel-thread issue scheduler: drives each thread's offset set,
// tracks issued slots to retire, and raises per-thread stall alarms on replays.
module thread_issue_scheduler
  import thread_issue_scheduler_pkg::*;
#(
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int READ_ADDR_WIDTH   = 10,
  parameter int WRITE_ADDR_WIDTH  = 12,
  parameter int ISSUE_PIPE_DEPTH  = 8,
  parameter int STALL_LIMIT       = 255
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [THREAD_COUNT-1:0]      thread_enable,
  input  logic                         cfg_wren,
  input  logic [THREAD_ADDR_WIDTH-1:0] cfg_thread,
  input  logic [1:0]                   cfg_sel,
  input  logic [WRITE_ADDR_WIDTH-1:0]  cfg_data,
  input  logic                         IO_ready,
  output logic [THREAD_ADDR_WIDTH-1:0] issue_thread,
  output logic                         issue_valid,
  output logic [READ_ADDR_WIDTH-1:0]   read_addr_A_offset,
  output logic [READ_ADDR_WIDTH-1:0]   read_addr_B_offset,
  output logic [WRITE_ADDR_WIDTH-1:0]  write_addr_A_offset,
  output logic [WRITE_ADDR_WIDTH-1:0]  write_addr_B_offset,
  output logic [THREAD_ADDR_WIDTH-1:0] retire_thread,
  output logic                         retire_advance,
  output logic                         retire_replay,
  output logic [THREAD_COUNT-1:0]      stall_alarm
);

  localparam replay_cnt_t STALL_LIMIT_C = replay_cnt_t'(STALL_LIMIT);

  logic [THREAD_ADDR_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
  logic [THREAD_ADDR_WIDTH-1:0] issue_thread_q, issue_thread_d;
  logic                         issue_valid_q, issue_valid_d;
  logic [READ_ADDR_WIDTH-1:0]   rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [WRITE_ADDR_WIDTH-1:0]  wr_a_q, wr_a_d, wr_b_q, wr_b_d;

  logic [READ_ADDR_WIDTH-1:0]   rd_a_tbl_q [THREAD_COUNT];
  logic [READ_ADDR_WIDTH-1:0]   rd_a_tbl_d [THREAD_COUNT];
  logic [READ_ADDR_WIDTH-1:0]   rd_b_tbl_q [THREAD_COUNT];
  logic [READ_ADDR_WIDTH-1:0]   rd_b_tbl_d [THREAD_COUNT];
  logic [WRITE_ADDR_WIDTH-1:0]  wr_a_tbl_q [THREAD_COUNT];
  logic [WRITE_ADDR_WIDTH-1:0]  wr_a_tbl_d [THREAD_COUNT];
  logic [WRITE_ADDR_WIDTH-1:0]  wr_b_tbl_q [THREAD_COUNT];
  logic [WRITE_ADDR_WIDTH-1:0]  wr_b_tbl_d [THREAD_COUNT];

  replay_cnt_t                  replay_cnt_q [THREAD_COUNT];
  replay_cnt_t                  replay_cnt_d [THREAD_COUNT];
  logic [THREAD_COUNT-1:0]      alarm_q, alarm_d;

  logic                         retire_valid;

  // Slot formation: the lookup reads the table before this cycle's write lands.
  always_comb begin
    slot_cnt_d     = slot_cnt_q + 1'b1;
    issue_thread_d = slot_cnt_q;
    issue_valid_d  = thread_enable[slot_cnt_q];
    rd_a_d         = rd_a_tbl_q[slot_cnt_q];
    rd_b_d         = rd_b_tbl_q[slot_cnt_q];
    wr_a_d         = wr_a_tbl_q[slot_cnt_q];
    wr_b_d         = wr_b_tbl_q[slot_cnt_q];
  end

  always_comb begin
    rd_a_tbl_d = rd_a_tbl_q;
    rd_b_tbl_d = rd_b_tbl_q;
    wr_a_tbl_d = wr_a_tbl_q;
    wr_b_tbl_d = wr_b_tbl_q;
    if (cfg_wren) begin
      unique case (ofs_sel_e'(cfg_sel))
        OFS_RD_A: rd_a_tbl_d[cfg_thread] = cfg_data[READ_ADDR_WIDTH-1:0];
        OFS_RD_B: rd_b_tbl_d[cfg_thread] = cfg_data[READ_ADDR_WIDTH-1:0];
        OFS_WR_A: wr_a_tbl_d[cfg_thread] = cfg_data;
        OFS_WR_B: wr_b_tbl_d[cfg_thread] = cfg_data;
      endcase
    end
  end

  thread_slot_delay #(
    .DEPTH    (ISSUE_PIPE_DEPTH),
    .THREAD_W (THREAD_ADDR_WIDTH)
  ) u_slot_delay (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_thread  (issue_thread_q),
    .in_valid   (issue_valid_q),
    .out_thread (retire_thread),
    .out_valid  (retire_valid)
  );

  assign retire_advance = retire_valid & IO_ready;
  assign retire_replay  = retire_valid & ~IO_ready;

  // The alarm compares against the post-increment count so it fires on the limit-th replay.
  always_comb begin
    replay_cnt_d = replay_cnt_q;
    alarm_d      = alarm_q;
    for (int t = 0; t < THREAD_COUNT; t++) begin
      if (retire_thread == THREAD_ADDR_WIDTH'(t)) begin
        if (retire_advance) begin
          replay_cnt_d[t] = '0;
        end else if (retire_replay) begin
          replay_cnt_d[t] = sat_inc(replay_cnt_q[t]);
          if (sat_inc(replay_cnt_q[t]) >= STALL_LIMIT_C) begin
            alarm_d[t] = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_q     <= '0;
      issue_thread_q <= '0;
      issue_valid_q  <= 1'b0;
      rd_a_q         <= '0;
      rd_b_q         <= '0;
      wr_a_q         <= '0;
      wr_b_q         <= '0;
      alarm_q        <= '0;
      for (int t = 0; t < THREAD_COUNT; t++) begin
        rd_a_tbl_q[t]   <= '0;
        rd_b_tbl_q[t]   <= '0;
        wr_a_tbl_q[t]   <= '0;
        wr_b_tbl_q[t]   <= '0;
        replay_cnt_q[t] <= '0;
      end
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      issue_thread_q <= issue_thread_d;
      issue_valid_q  <= issue_valid_d;
      rd_a_q         <= rd_a_d;
      rd_b_q         <= rd_b_d;
      wr_a_q         <= wr_a_d;
      wr_b_q         <= wr_b_d;
      alarm_q        <= alarm_d;
      rd_a_tbl_q     <= rd_a_tbl_d;
      rd_b_tbl_q     <= rd_b_tbl_d;
      wr_a_tbl_q     <= wr_a_tbl_d;
      wr_b_tbl_q     <= wr_b_tbl_d;
      replay_cnt_q   <= replay_cnt_d;
    end
  end

  assign issue_thread        = issue_thread_q;
  assign issue_valid         = issue_valid_q;
  assign read_addr_A_offset  = rd_a_q;
  assign read_addr_B_offset  = rd_b_q;
  assign write_addr_A_offset = wr_a_q;
  assign write_addr_B_offset = wr_b_q;
  assign stall_alarm         = alarm_q;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Directed bench for thread_issue_scheduler (8 threads, depth 8, stall limit 4):
// reset, offset table, disabled threads, replay alarm, mid-flight reset.
module tb_thread_issue_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  thread_enable;
  logic        cfg_wren;
  logic [2:0]  cfg_thread;
  logic [1:0]  cfg_sel;
  logic [11:0] cfg_data;
  logic        IO_ready;
  logic [2:0]  issue_thread;
  logic        issue_valid;
  logic [9:0]  read_addr_A_offset, read_addr_B_offset;
  logic [11:0] write_addr_A_offset, write_addr_B_offset;
  logic [2:0]  retire_thread;
  logic        retire_advance, retire_replay;
  logic [7:0]  stall_alarm;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  thread_issue_scheduler #(
    .THREAD_COUNT      (8),
    .THREAD_ADDR_WIDTH (3),
    .READ_ADDR_WIDTH   (10),
    .WRITE_ADDR_WIDTH  (12),
    .ISSUE_PIPE_DEPTH  (8),
    .STALL_LIMIT       (4)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .thread_enable       (thread_enable),
    .cfg_wren            (cfg_wren),
    .cfg_thread          (cfg_thread),
    .cfg_sel             (cfg_sel),
    .cfg_data            (cfg_data),
    .IO_ready            (IO_ready),
    .issue_thread        (issue_thread),
    .issue_valid         (issue_valid),
    .read_addr_A_offset  (read_addr_A_offset),
    .read_addr_B_offset  (read_addr_B_offset),
    .write_addr_A_offset (write_addr_A_offset),
    .write_addr_B_offset (write_addr_B_offset),
    .retire_thread       (retire_thread),
    .retire_advance      (retire_advance),
    .retire_replay       (retire_replay),
    .stall_alarm         (stall_alarm)
  );

  always #5 clock = ~clock;

  // One clock edge; cyc counts slots since the last reset release (slot 0 = thread 0).
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_phase(input int phase);
    for (int i = 0; i < 8 && (cyc % 8) != phase; i++) step();
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    thread_enable = 8'hFF;
    IO_ready      = 1'b1;
    cfg_wren      = 1'b0;
    cfg_thread    = '0;
    cfg_sel       = '0;
    cfg_data      = '0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (issue_thread !== 3'd0) begin bad++; $display("FAIL reset_issue_thread got=%0d want=0", issue_thread); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b want=0", issue_valid); end
    total++; if ({read_addr_A_offset, read_addr_B_offset, write_addr_A_offset, write_addr_B_offset} !== 44'd0) begin
      bad++; $display("FAIL reset_offsets got=%h/%h/%h/%h want=0", read_addr_A_offset, read_addr_B_offset, write_addr_A_offset, write_addr_B_offset); end
    total++; if ({retire_thread, retire_advance, retire_replay} !== 5'd0) begin
      bad++; $display("FAIL reset_retire got thread=%0d adv=%b rep=%b want=0/0/0", retire_thread, retire_advance, retire_replay); end
    total++; if (stall_alarm !== 8'h00) begin bad++; $display("FAIL reset_alarm got=%h want=00", stall_alarm); end
    reset_n = 1'b1;
    cyc = -1;
    for (int i = 0; i <= 8; i++) begin
      step();
      total++; if (issue_thread !== 3'(i)) begin bad++; $display("FAIL rr_thread slot=%0d got=%0d want=%0d", i, issue_thread, i % 8); end
      total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL rr_valid slot=%0d got=%b want=1", i, issue_valid); end
      total++; if ({read_addr_A_offset, read_addr_B_offset, write_addr_A_offset, write_addr_B_offset} !== 44'd0) begin
        bad++; $display("FAIL rr_offsets slot=%0d got nonzero want=0", i); end
      total++; if (retire_advance !== (i == 8)) begin bad++; $display("FAIL first_retire slot=%0d got=%b want=%b", i, retire_advance, i == 8); end
      total++; if (retire_replay !== 1'b0) begin bad++; $display("FAIL first_replay slot=%0d got=%b want=0", i, retire_replay); end
    end
  endtask

  task automatic test_cfg_write();
    wait_phase(1);
    // Thread 3 read B written while thread 2's slot is being formed.
    cfg_wren = 1'b1; cfg_thread = 3'd3; cfg_sel = 2'd1; cfg_data = 12'h02A;
    step();
    cfg_wren = 1'b0;
    total++; if (issue_thread !== 3'd2 || read_addr_B_offset !== 10'h000) begin
      bad++; $display("FAIL cfg_thread2 got thread=%0d rdb=%h want 2/000", issue_thread, read_addr_B_offset); end
    step();
    total++; if (issue_thread !== 3'd3 || read_addr_B_offset !== 10'h02A) begin
      bad++; $display("FAIL cfg_rdb_t3 got thread=%0d rdb=%h want 3/02a", issue_thread, read_addr_B_offset); end
    total++; if ({read_addr_A_offset, write_addr_A_offset, write_addr_B_offset} !== 34'd0) begin
      bad++; $display("FAIL cfg_other_sel_t3 got %h/%h/%h want 0", read_addr_A_offset, write_addr_A_offset, write_addr_B_offset); end
    step();
    total++; if (read_addr_B_offset !== 10'h000) begin bad++; $display("FAIL cfg_rdb_t4 got=%h want=000", read_addr_B_offset); end
    // Thread 5 write A written in the very cycle thread 5's slot is looked up: old value first.
    cfg_wren = 1'b1; cfg_thread = 3'd5; cfg_sel = 2'd2; cfg_data = 12'hABC;
    step();
    total++; if (issue_thread !== 3'd5 || write_addr_A_offset !== 12'h000) begin
      bad++; $display("FAIL cfg_same_cycle got thread=%0d wra=%h want 5/000", issue_thread, write_addr_A_offset); end
    // Read offsets keep only the low 10 bits.
    cfg_thread = 3'd7; cfg_sel = 2'd0; cfg_data = 12'hFFF;
    step();
    cfg_wren = 1'b0;
    step();
    total++; if (issue_thread !== 3'd7 || read_addr_A_offset !== 10'h3FF) begin
      bad++; $display("FAIL cfg_rda_trunc got thread=%0d rda=%h want 7/3ff", issue_thread, read_addr_A_offset); end
    wait_phase(3);
    total++; if (read_addr_B_offset !== 10'h02A) begin bad++; $display("FAIL cfg_rdb_hold got=%h want=02a", read_addr_B_offset); end
    wait_phase(5);
    total++; if (write_addr_A_offset !== 12'hABC || read_addr_A_offset !== 10'h000) begin
      bad++; $display("FAIL cfg_wra_t5 got wra=%h rda=%h want abc/000", write_addr_A_offset, read_addr_A_offset); end
  endtask

  task automatic test_disable();
    thread_enable = 8'hFD;
    for (int i = 0; i < 24; i++) begin
      step();
      total++; if (issue_valid !== ((cyc % 8) != 1)) begin
        bad++; $display("FAIL dis_issue_valid thread=%0d got=%b want=%b", cyc % 8, issue_valid, (cyc % 8) != 1); end
      if (i >= 8) begin
        IO_ready = ((cyc % 8) != 1);
        #1;
        total++; if (retire_advance !== ((cyc % 8) != 1) || retire_replay !== 1'b0) begin
          bad++; $display("FAIL dis_retire thread=%0d got adv=%b rep=%b want adv=%b rep=0", cyc % 8, retire_advance, retire_replay, (cyc % 8) != 1); end
        IO_ready = 1'b1;
      end
    end
    thread_enable = 8'hFF;
    repeat (10) step();
  endtask

  task automatic test_replay_alarm();
    logic [7:0] mask;
    wait_phase(0);
    for (int i = 0; i < 32; i++) begin
      IO_ready = 1'b0;
      #1;
      mask = '0;
      for (int t = 0; t < 8; t++) if (24 + t < i) mask[t] = 1'b1;
      total++; if (retire_replay !== 1'b1 || retire_advance !== 1'b0 || retire_thread !== 3'(i)) begin
        bad++; $display("FAIL replay i=%0d got rep=%b adv=%b thread=%0d want 1/0/%0d", i, retire_replay, retire_advance, retire_thread, i % 8); end
      total++; if (stall_alarm !== mask) begin bad++; $display("FAIL alarm_build i=%0d got=%h want=%h", i, stall_alarm, mask); end
      step();
    end
    IO_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (retire_advance !== 1'b1 || stall_alarm !== 8'hFF) begin
        bad++; $display("FAIL alarm_sticky i=%0d got adv=%b alarm=%h want 1/ff", i, retire_advance, stall_alarm); end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    reset_n  = 1'b0;
    IO_ready = 1'b0;
    #1;
    total++; if (retire_advance !== 1'b0 || retire_replay !== 1'b0) begin
      bad++; $display("FAIL midrst_retire got adv=%b rep=%b want 0/0", retire_advance, retire_replay); end
    total++; if (issue_valid !== 1'b0 || stall_alarm !== 8'h00) begin
      bad++; $display("FAIL midrst_state got valid=%b alarm=%h want 0/00", issue_valid, stall_alarm); end
    step();
    IO_ready = 1'b1;
    #1;
    total++; if (retire_advance !== 1'b0 || retire_replay !== 1'b0) begin
      bad++; $display("FAIL midrst_hold got adv=%b rep=%b want 0/0", retire_advance, retire_replay); end
    reset_n = 1'b1;
    cyc = -1;
    for (int i = 0; i <= 8; i++) begin
      step();
      total++; if (issue_valid !== 1'b1 || issue_thread !== 3'(i)) begin
        bad++; $display("FAIL midrst_issue slot=%0d got valid=%b thread=%0d want 1/%0d", i, issue_valid, issue_thread, i % 8); end
      total++; if (retire_advance !== (i == 8)) begin
        bad++; $display("FAIL midrst_first_retire slot=%0d got=%b want=%b", i, retire_advance, i == 8); end
    end
  endtask

  // Thread 0 sees replay,replay,replay,advance then four replays: only the last run reaches 4.
  task automatic test_counter_clear();
    logic [7:0] pattern;
    pattern = 8'b0000_1000;
    for (int n = 0; n <= 64; n++) begin
      if ((n % 8) == 0 && n < 64) IO_ready = pattern[n/8];
      else IO_ready = 1'b1;
      #1;
      total++; if (stall_alarm !== {7'd0, n > 56}) begin
        bad++; $display("FAIL cnt_clear n=%0d got=%h want=%h", n, stall_alarm, {7'd0, n > 56}); end
      if (n == 24) begin
        total++; if (retire_advance !== 1'b1 || retire_thread !== 3'd0) begin
          bad++; $display("FAIL cnt_clear_adv got adv=%b thread=%0d want 1/0", retire_advance, retire_thread); end
      end
      step();
    end
    IO_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cfg_write();
    test_disable();
    test_replay_alarm();
    test_reset_midflight();
    test_counter_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
